// File: rtl/spi_target_rx_tx.sv
// spi_target_rx_tx: oversampled SPI target with full-duplex DATA_W-bit frames and valid/ready byte ports.
// Define SPI_TGT_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_target_rx_tx #(
  parameter int DATA_W = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(8'hFF)
) (
  input  logic              i2c_wb_clk_i,
  input  logic              i2c_wb_rst_i,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              ovr_o,
  output logic              udr_o,
  input  logic              flag_clr_i,
  output logic              busy_o
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic {IDLE, SEL} state_t;
  state_t state_q, state_d;
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic [DATA_W-1:0] tx_sr, tx_buf, tx_shift, rx_next;
  logic [DATA_W-2:0] rx_sr, rx_keep;
  logic [CW-1:0] bit_cnt;
  logic tx_full, frame_done, rise, fall, samp, drv, cs_fall;
  logic do_load, do_shift, do_samp, word_done, tx_acc, miso_bit;
  assign rise = sck_q[1] & ~sck_q[2];
  assign fall = ~sck_q[1] & sck_q[2];
  assign samp = (CPOL ^ CPHA) ? fall : rise;
  assign drv = (CPOL ^ CPHA) ? rise : fall;
  assign cs_fall = cs_q[2] & ~cs_q[1];
`ifdef SPI_TGT_LSB_FIRST_EN
  assign rx_next = {mosi_q[1], rx_sr};
  assign rx_keep = rx_next[DATA_W-1:1];
  assign tx_shift = {1'b0, tx_sr[DATA_W-1:1]};
  assign miso_bit = tx_sr[0];
`else
  assign rx_next = {rx_sr, mosi_q[1]};
  assign rx_keep = rx_next[DATA_W-2:0];
  assign tx_shift = {tx_sr[DATA_W-2:0], 1'b0};
  assign miso_bit = tx_sr[DATA_W-1];
`endif
  assign word_done = do_samp & (bit_cnt == CW'(DATA_W - 1));
  assign tx_acc = tx_valid_i & ~tx_full;
  assign tx_ready_o = ~tx_full;
  assign miso_oe = state_q == SEL;
  assign miso_o = miso_oe & miso_bit;
  assign busy_o = ~cs_q[1];
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_shift = 1'b0;
    do_samp = 1'b0;
    if (state_q == IDLE) begin
      state_d = cs_fall ? SEL : IDLE;
      do_load = cs_fall & ~CPHA;
    end else if (cs_q[1]) begin
      state_d = IDLE;
    end else begin
      do_samp = samp;
      do_load = drv & (CPHA ? bit_cnt == '0 : frame_done);
      do_shift = drv & ~do_load;
    end
  end
  // a load sees the pre-accept holding register, so an accept in the same cycle refills it
  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q <= IDLE;
      sck_q <= {3{CPOL}};
      cs_q <= 3'b111;
      mosi_q <= '0;
      tx_sr <= '0;
      tx_buf <= '0;
      tx_full <= 1'b0;
      rx_sr <= '0;
      bit_cnt <= '0;
      frame_done <= 1'b0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      ovr_o <= 1'b0;
      udr_o <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q <= {sck_q[1:0], sck_i};
      cs_q <= {cs_q[1:0], cs_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
      if (do_load) tx_sr <= tx_full ? tx_buf : FILL;
      else if (do_shift) tx_sr <= tx_shift;
      if (tx_acc) tx_buf <= tx_data_i;
      tx_full <= (tx_full & ~do_load) | tx_acc;
      if (do_samp) rx_sr <= rx_keep;
      if (state_d == IDLE) bit_cnt <= '0;
      else if (do_samp) bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      frame_done <= (state_d == SEL) & (word_done | (frame_done & ~drv));
      if (word_done) rx_data_o <= rx_next;
      rx_valid_o <= word_done | (rx_valid_o & ~rx_ready_i);
      ovr_o <= (word_done & rx_valid_o & ~rx_ready_i) | (ovr_o & ~flag_clr_i);
      udr_o <= (do_load & ~tx_full) | (udr_o & ~flag_clr_i);
    end
  end
endmodule

// File: tb/tb_spi_target_rx_tx.sv
// tb_spi_target_rx_tx: bit-banged SPI master against mode-0 and mode-3 targets with a frame-level model.
module tb_spi_target_rx_tx;
  localparam int H = 6;
  localparam logic [7:0] FILL = 8'hFF;
  logic clk = 0, rst = 1, m = 0, cs = 1, sck = 0, mosi = 0, tv = 0, rr = 0, fc = 0, chk_en = 0;
  logic [7:0] td = 0;
  logic miso_a, oe_a, txr_a, rxv_a, ovr_a, udr_a, busy_a;
  logic miso_b, oe_b, txr_b, rxv_b, ovr_b, udr_b, busy_b;
  logic [7:0] rxd_a, rxd_b;
  logic miso, oe, txr, rxv, ovr, udr, busy;
  logic [7:0] rxd;
  int pass = 0, total = 0, ci = 0;
  logic [7:0] mo_w[4], mi_w[4];
  logic [7:0] dq[$], mq[$], exp_q[$], got_q[$];
  logic m_rxv = 0, m_ovr = 0, m_udr = 0;
  logic [7:0] m_rxd = 0;
  always #5 clk = ~clk;
  spi_target_rx_tx #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .i2c_wb_clk_i(clk), .i2c_wb_rst_i(rst), .sck_i(m ? 1'b0 : sck), .cs_n_i(m | cs), .mosi_i(mosi),
    .miso_o(miso_a), .miso_oe(oe_a), .tx_data_i(td), .tx_valid_i(~m & tv), .tx_ready_o(txr_a),
    .rx_data_o(rxd_a), .rx_valid_o(rxv_a), .rx_ready_i(rr), .ovr_o(ovr_a), .udr_o(udr_a),
    .flag_clr_i(fc), .busy_o(busy_a));
  spi_target_rx_tx #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .i2c_wb_clk_i(clk), .i2c_wb_rst_i(rst), .sck_i(m ? sck : 1'b1), .cs_n_i(~m | cs), .mosi_i(mosi),
    .miso_o(miso_b), .miso_oe(oe_b), .tx_data_i(td), .tx_valid_i(m & tv), .tx_ready_o(txr_b),
    .rx_data_o(rxd_b), .rx_valid_o(rxv_b), .rx_ready_i(rr), .ovr_o(ovr_b), .udr_o(udr_b),
    .flag_clr_i(fc), .busy_o(busy_b));
  assign miso = m ? miso_b : miso_a;
  assign oe = m ? oe_b : oe_a;
  assign txr = m ? txr_b : txr_a;
  assign rxv = m ? rxv_b : rxv_a;
  assign rxd = m ? rxd_b : rxd_a;
  assign ovr = m ? ovr_b : ovr_a;
  assign udr = m ? udr_b : udr_a;
  assign busy = m ? busy_b : busy_a;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    #1;
    if (chk_en) chk("outputs", {rxv, rxd, ovr, udr, txr, busy, oe, miso},
                    {m_rxv, m_rxd, m_ovr, m_udr, mq.size() == 0, 3'b000});
  end
  always @(negedge clk) begin
    #1;
    if (!rst && rxv && rr) got_q.push_back(rxd);
  end
  initial forever begin
    @(negedge clk);
    if (!rst && dq.size() != 0 && txr) begin
      tv = 1;
      td = dq[0];
      @(negedge clk);
      tv = 0;
      void'(dq.pop_front());
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic xfer(input int nb);
    cs = 0;
    wt(8);
    for (int i = 0; i < nb; i++) begin
      if (!m) begin
        mosi = mo_w[i/8][7-(i%8)];
        wt(H);
        mi_w[i/8][7-(i%8)] = miso;
        sck = 1;
        wt(H);
        if (i == nb - 1) begin
          cs = 1;
          wt(H);
        end
        sck = 0;
      end else begin
        sck = 0;
        mosi = mo_w[i/8][7-(i%8)];
        wt(H);
        mi_w[i/8][7-(i%8)] = miso;
        sck = 1;
        wt(H);
      end
    end
    cs = 1;
    wt(4);
  endtask
  task automatic push_tx(input logic [7:0] w);
    chk_en = 0;
    dq.push_back(w);
    mq.push_back(w);
  endtask
  task automatic chk_rx();
    chk("rx_count", got_q.size(), exp_q.size());
    for (int i = ci; i < exp_q.size() && i < got_q.size(); i++) chk("rx_word", got_q[i], exp_q[i]);
    ci = exp_q.size();
  endtask
  // every started frame loads one TX word (or FILL); every complete frame delivers one RX word
  task automatic run(input int nb);
    logic [7:0] w;
    chk_en = 0;
    xfer(nb);
    wt(4);
    for (int f = 0; f < (nb + 7) / 8; f++) begin
      if (mq.size() != 0) w = mq.pop_front();
      else begin
        w = FILL;
        m_udr = 1;
      end
      if (f < nb / 8) begin
        chk("miso_word", mi_w[f], w);
        if (m_rxv && !rr) m_ovr = 1;
        m_rxd = mo_w[f];
        if (rr) exp_q.push_back(mo_w[f]);
        m_rxv = !rr;
      end
    end
    chk_rx();
    chk_en = 1;
  endtask
  task automatic set_rr(input logic v);
    chk_en = 0;
    rr = v;
    wt(3);
    if (v && m_rxv) begin
      exp_q.push_back(m_rxd);
      m_rxv = 0;
    end
    chk_en = 1;
  endtask
  task automatic clr();
    chk_en = 0;
    @(negedge clk) fc = 1;
    @(negedge clk) fc = 0;
    m_ovr = 0;
    m_udr = 0;
    wt(2);
    chk_en = 1;
  endtask
  task automatic mreset();
    m_rxv = 0;
    m_rxd = 0;
    m_ovr = 0;
    m_udr = 0;
    mq.delete();
    dq.delete();
    exp_q.delete();
    got_q.delete();
    ci = 0;
  endtask
  task automatic rnd(input int n);
    repeat (n) begin
      int nf, nt;
      chk_en = 0;
      nf = $urandom_range(1, 3);
      nt = $urandom_range(0, nf);
      for (int f = 0; f < nf; f++) mo_w[f] = 8'($urandom);
      for (int t = 0; t < nt; t++) push_tx(8'($urandom));
      set_rr(1'($urandom_range(0, 1)));
      run(nf * 8);
      if ($urandom_range(0, 3) == 0) clr();
      if ($urandom_range(0, 3) == 0) set_rr(1);
    end
  endtask
  initial begin
    int g;
    wt(3);
    chk_en = 1;
    wt(2);
    chk("rst_txr", txr, 1);
    chk("rst_rxv", rxv, 0);
    chk("rst_oe", oe, 0);
    rst = 0;
    wt(4);
    push_tx(8'hA5);
    set_rr(0);
    mo_w[0] = 8'h3C;
    run(8);
    chk("t1_miso", mi_w[0], 8'hA5);
    chk("t1_rxd", rxd, 8'h3C);
    chk("t1_rxv", rxv, 1);
    chk("t1_txr", txr, 1);
    chk("t1_udr", udr, 0);
    push_tx(8'h11);
    push_tx(8'h22);
    set_rr(1);
    mo_w[0] = 8'h01;
    mo_w[1] = 8'h02;
    run(16);
    chk("t2_miso0", mi_w[0], 8'h11);
    chk("t2_miso1", mi_w[1], 8'h22);
    chk("t2_rx_last", got_q[got_q.size()-1], 8'h02);
    chk("t2_flags", {ovr, udr}, 2'b00);
    mo_w[0] = 8'h55;
    run(8);
    chk("t3_miso", mi_w[0], 8'hFF);
    chk("t3_udr", udr, 1);
    clr();
    chk("t3_udr_clr", udr, 0);
    set_rr(0);
    mo_w[0] = 8'h10;
    run(8);
    mo_w[0] = 8'h20;
    run(8);
    chk("t4_rxd", rxd, 8'h20);
    chk("t4_ovr", ovr, 1);
    wt(5);
    chk("t4_rxv_held", rxv, 1);
    set_rr(1);
    chk("t4_rxv_done", rxv, 0);
    clr();
    g = got_q.size();
    mo_w[0] = 8'hF0;
    run(5);
    mo_w[0] = 8'hC3;
    run(8);
    chk("t5_count", got_q.size() - g, 1);
    chk("t5_word", got_q[got_q.size()-1], 8'hC3);
    clr();
    rnd(12);
    chk_en = 0;
    rst = 1;
    m = 1;
    sck = 1;
    wt(3);
    mreset();
    chk_en = 1;
    wt(2);
    rst = 0;
    wt(4);
    push_tx(8'h96);
    set_rr(0);
    mo_w[0] = 8'h69;
    run(8);
    chk("t6_miso", mi_w[0], 8'h96);
    chk("t6_rxd", rxd, 8'h69);
    set_rr(1);
    chk_en = 0;
    mo_w[0] = 8'hE7;
    mo_w[1] = 8'h18;
    fork
      xfer(16);
      begin
        wt(40);
        rst = 1;
        @(negedge clk);
        mreset();
        chk_en = 1;
        wt(2);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_oe", oe, 0);
        chk("rst_mid_txr", txr, 1);
      end
    join
    wt(2);
    rst = 0;
    wt(4);
    push_tx(8'hA3);
    mo_w[0] = 8'h5C;
    run(8);
    chk("t7_miso", mi_w[0], 8'hA3);
    chk("t7_rxd", rxd, 8'h5C);
    rnd(12);
    chk_en = 0;
    chk_rx();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/spi_target_rx_tx.md
Name: spi_target_rx_tx

Overview:
- SPI target (slave) endpoint: the responder for the bridge's SPI master port (sck/mosi/miso).
- Used as an on-chip loopback/peer for bridge bring-up, and as a standalone SPI peripheral on spare pins.
- Oversamples external SCK/CS_N/MOSI in the system clock domain, shifts full-duplex DATA_W-bit frames, and exposes byte-level valid/ready interfaces to internal logic.

Parameters:
- DATA_W, 8, frame width in bits (4..16).
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge / drive on trailing edge; 1 = drive on leading edge / sample on trailing edge.
- FILL, 8'hFF, MISO word sent when no TX data is queued (DATA_W bits, zero-extended).

Ports:
- i2c_wb_clk_i  in  1  system clock; all logic on rising edge.
- i2c_wb_rst_i  in  1  reset: synchronous, active-high.
- sck_i  in  1  external SPI clock (async).
- cs_n_i  in  1  external chip select, active low (async).
- mosi_i  in  1  external serial data in (async).
- miso_o  out  1  serial data out.
- miso_oe  out  1  MISO output enable (1 while selected).
- tx_data_i  in  DATA_W  next word to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX holding register empty.
- rx_data_o  out  DATA_W  last received word.
- rx_valid_o  out  1  rx_data_o holds an unconsumed word.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- ovr_o  out  1  sticky: RX word overwritten before being consumed.
- udr_o  out  1  sticky: frame started with empty TX register (FILL sent).
- flag_clr_i  in  1  clears ovr_o and udr_o.
- busy_o  out  1  CS synchronised low.

Behaviour:
- Synchronisers: sck_i, cs_n_i, mosi_i each pass through 2 FFs plus 1 history FF for edge detection. Reset values: sck = CPOL, cs_n = 1, mosi = 0.
- SCK frequency must be ≤ clk/8. Any SCK edge is acted on exactly 3 clk cycles after the pin change.
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Drive edge = the other edge.
- FSM has two states:
  - IDLE: cs_s=1. SCK edges are ignored; bit_cnt = 0.
  - SEL: entered on the cs_s falling edge; returns to IDLE on cs_s=1.
- TX loading:
  - A load takes tx_buf if full (clears full) or else FILL (sets udr_o).
  - CPHA=0: load on IDLE->SEL entry, and on the first drive edge after a completed frame. All other drive edges shift left.
  - CPHA=1: load on a drive edge when bit_cnt=0. All other drive edges shift left.
- miso_o = tx_sr[DATA_W-1] in SEL, 0 in IDLE. miso_oe = 1 in SEL.
- TX handshake: tx_ready_o = ~tx_full; a word is accepted when tx_valid_i & tx_ready_o.
  - A load and an accept in the same cycle: the load takes the old content (or FILL), then the new word is captured.
- RX path: each sample edge does rx_sr <= {rx_sr[DATA_W-2:0], mosi_s} and bit_cnt++.
  - When bit_cnt reaches DATA_W, the full word is copied to rx_data_o in the same cycle, rx_valid_o <= 1, and bit_cnt <= 0.
- RX handshake: rx_valid_o clears on rx_valid_o & rx_ready_i.
  - A new word arriving while rx_valid_o=1 overwrites rx_data_o, keeps rx_valid_o=1, and sets ovr_o.
  - A new word arriving in the same cycle as a handshake: the handshake consumes the old word; rx_valid_o stays 1 with the new word; no overrun.
- Sticky flags: flag_clr_i clears ovr_o/udr_o. A set condition in the same cycle as the clear wins.
- CS deassert mid-frame: partial RX bits are discarded, bit_cnt <= 0, no rx_valid_o. A TX word already loaded counts as consumed.
- Reset (any time, including mid-frame): FSM to IDLE, all registers cleared, tx_full = 0. Output values during reset:
  - tx_ready_o = 1.
  - miso_o, miso_oe, rx_data_o, rx_valid_o, ovr_o, udr_o, busy_o = 0.

Optional Feature:
- SPI_TGT_LSB_FIRST_EN:
  - When defined: both directions are LSB-first. miso_o = tx_sr[0], shifts are rightward, and RX bits enter at the MSB.
  - When undefined: MSB-first as described above.
  - Port list is unchanged either way.

Test Plan:
- Mode 0, tx 0xA5 queued, master sends 0x3C in one CS frame -> master receives 0xA5; rx_data_o=0x3C, rx_valid_o=1; tx_ready_o back to 1; udr_o=0.
- Two back-to-back frames under one CS, tx 0x11 then 0x22, master sends 0x01,0x02 -> MISO gives 0x11,0x22; two rx words 0x01,0x02 with rx_ready_i held high; flags stay 0.
- No TX queued, master sends 0x55 -> MISO gives 0xFF; udr_o=1. Then flag_clr_i pulse -> udr_o=0.
- rx_ready_i=0, master sends 0x10 then 0x20 -> rx_data_o=0x20; ovr_o=1; rx_valid_o stays 1 until the handshake.
- CS raised after 5 bits, then a full frame 0xC3 -> only 0xC3 is reported, one rx_valid_o rise.
- CPOL=1/CPHA=1 instance, tx 0x96, rx 0x69 -> exchange correct. Reset asserted mid-frame -> all outputs at reset values; next frame exchanges correctly.
